// File: rtl/pwm_capture.sv
// PWM capture: measures high time and rise-to-rise period of an asynchronous PWM line
// in clk cycles, reports each complete period with a one-cycle strobe and flags a stuck line.
module pwm_capture #(
    parameter int CNT_W       = 16,
    parameter int TIMEOUT     = 50000,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] duty_out,
    output logic [CNT_W-1:0] period_out,
    output logic             valid,
    output logic             stuck,
    output logic             stuck_level
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HIGH = 2'd1;
    localparam logic [1:0] ST_LOW  = 2'd2;

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ZERO_C    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE_C     = {{(CNT_W-1){1'b0}}, 1'b1};

    // Counters stop at TIMEOUT so they can never wrap into a false short measurement.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v >= TIMEOUT_C) begin
            sat_inc = TIMEOUT_C;
        end else begin
            sat_inc = v + ONE_C;
        end
    endfunction

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   rise_q;
    logic                   fall_q;
    logic                   s_s;
    logic                   rise_s;
    logic                   fall_s;

    logic [1:0]       state_q,      state_d;
    logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
    logic [CNT_W-1:0] high_cnt_q,   high_cnt_d;
    logic [CNT_W-1:0] idle_cnt_q,   idle_cnt_d;
    logic [CNT_W-1:0] duty_q,       duty_d;
    logic [CNT_W-1:0] period_q,     period_d;
    logic             valid_q,      valid_d;
    logic             stuck_q,      stuck_d;
    logic             stuck_lvl_q,  stuck_lvl_d;

    assign s_s    = sync_q[SYNC_STAGES-1];
    assign rise_s = s_s & ~prev_q;
    assign fall_s = ~s_s & prev_q;

    // Input synchronizer and registered edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= {SYNC_STAGES{1'b0}};
            prev_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
            prev_q <= s_s;
            rise_q <= rise_s;
            fall_q <= fall_s;
        end
    end

    // Measurement FSM, timeout detection and result capture.
    always_comb begin
        state_d      = state_q;
        period_cnt_d = period_cnt_q;
        high_cnt_d   = high_cnt_q;
        idle_cnt_d   = idle_cnt_q;
        duty_d       = duty_q;
        period_d     = period_q;
        valid_d      = 1'b0;
        stuck_d      = stuck_q;
        stuck_lvl_d  = stuck_lvl_q;
        if (!en) begin
            state_d      = ST_IDLE;
            period_cnt_d = ZERO_C;
            high_cnt_d   = ZERO_C;
            idle_cnt_d   = ZERO_C;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rise_q) begin
                        state_d      = ST_HIGH;
                        period_cnt_d = ONE_C;
                        high_cnt_d   = ONE_C;
                        idle_cnt_d   = ZERO_C;
                        stuck_d      = 1'b0;
                    end else begin
                        idle_cnt_d = sat_inc(idle_cnt_q);
                        if ((idle_cnt_q == TIMEOUT_C) && !stuck_q) begin
                            stuck_d     = 1'b1;
                            stuck_lvl_d = s_s;
                        end else begin
                            stuck_d = stuck_q;
                        end
                    end
                end
                ST_HIGH: begin
                    if (period_cnt_q == TIMEOUT_C) begin
                        state_d      = ST_IDLE;
                        period_cnt_d = ZERO_C;
                        high_cnt_d   = ZERO_C;
                        idle_cnt_d   = ZERO_C;
                        stuck_d      = 1'b1;
                        stuck_lvl_d  = s_s;
                    end else begin
                        period_cnt_d = sat_inc(period_cnt_q);
                        if (fall_q) begin
                            state_d = ST_LOW;
                        end else begin
                            high_cnt_d = sat_inc(high_cnt_q);
                        end
                    end
                end
                ST_LOW: begin
                    // A closing rise takes precedence over a timeout in the same cycle.
                    if (rise_q) begin
                        state_d      = ST_HIGH;
                        duty_d       = high_cnt_q;
                        period_d     = period_cnt_q;
                        valid_d      = 1'b1;
                        period_cnt_d = ONE_C;
                        high_cnt_d   = ONE_C;
                    end else if (period_cnt_q == TIMEOUT_C) begin
                        state_d      = ST_IDLE;
                        period_cnt_d = ZERO_C;
                        high_cnt_d   = ZERO_C;
                        idle_cnt_d   = ZERO_C;
                        stuck_d      = 1'b1;
                        stuck_lvl_d  = s_s;
                    end else begin
                        period_cnt_d = sat_inc(period_cnt_q);
                    end
                end
                default: begin
                    state_d      = ST_IDLE;
                    period_cnt_d = ZERO_C;
                    high_cnt_d   = ZERO_C;
                    idle_cnt_d   = ZERO_C;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            period_cnt_q <= ZERO_C;
            high_cnt_q   <= ZERO_C;
            idle_cnt_q   <= ZERO_C;
            duty_q       <= ZERO_C;
            period_q     <= ZERO_C;
            valid_q      <= 1'b0;
            stuck_q      <= 1'b0;
            stuck_lvl_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            period_cnt_q <= period_cnt_d;
            high_cnt_q   <= high_cnt_d;
            idle_cnt_q   <= idle_cnt_d;
            duty_q       <= duty_d;
            period_q     <= period_d;
            valid_q      <= valid_d;
            stuck_q      <= stuck_d;
            stuck_lvl_q  <= stuck_lvl_d;
        end
    end

    assign duty_out    = duty_q;
    assign period_out  = period_q;
    assign valid       = valid_q;
    assign stuck       = stuck_q;
    assign stuck_level = stuck_lvl_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: stimulus pushes expected measurements derived from the
// driven pin waveform; a monitor pops and compares on every valid strobe.
module tb_pwm_capture;

    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 500;
    localparam int SYNC    = 2;
    localparam int LAT     = SYNC + 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             pwm_in;
    logic [CNT_W-1:0] duty_out;
    logic [CNT_W-1:0] period_out;
    logic             valid;
    logic             stuck;
    logic             stuck_level;

    always #5 clk = ~clk;

    pwm_capture #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .rst(rst), .en(en), .pwm_in(pwm_in),
        .duty_out(duty_out), .period_out(period_out), .valid(valid),
        .stuck(stuck), .stuck_level(stuck_level)
    );

    typedef struct {
        longint duty;
        longint period;
        longint due;
    } exp_t;

    exp_t   sb_q[$];
    int     n_tests = 0;
    int     n_fail  = 0;
    longint cyc     = 0;

    // Reference model state: pin history as seen from the stimulus side.
    logic   cur_pin   = 1'b0;
    bit     armed     = 1'b0;
    longint last_rise = 0;
    longint last_high = 0;
    longint last_duty = 0;
    longint last_per  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive the pin to v for n cycles; a rise closing an armed period of at most TIMEOUT cycles
    // is a reportable measurement.
    task automatic pin(input logic v, input int n);
        exp_t e;
        if (v && !cur_pin) begin
            if (armed && (cyc - last_rise) <= TIMEOUT) begin
                e.duty   = last_high;
                e.period = cyc - last_rise;
                e.due    = cyc + LAT;
                sb_q.push_back(e);
                last_duty = e.duty;
                last_per  = e.period;
            end
            armed     = 1'b1;
            last_rise = cyc;
        end else if (!v && cur_pin) begin
            last_high = cyc - last_rise;
        end
        pwm_in  = v;
        cur_pin = v;
        tick(n);
    endtask

    task automatic period(input int h, input int p);
        pin(1'b1, h);
        pin(1'b0, p - h);
    endtask

    task automatic mon_step();
        exp_t e;
        if (valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_valid: duty %0d period %0d at cycle %0d, none expected",
                         duty_out, period_out, cyc);
            end else begin
                e = sb_q.pop_front();
                check("duty", 64'(duty_out), 64'(e.duty));
                check("period", 64'(period_out), 64'(e.period));
                check("latency", 64'(cyc), 64'(e.due));
                check("stuck_on_valid", 64'(stuck), 64'd0);
            end
        end
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                mon_step();
            end
        join_none

        rst    = 1'b1;
        en     = 1'b1;
        pwm_in = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("rst_duty", 64'(duty_out), 64'd0);
        check("rst_period", 64'(period_out), 64'd0);
        check("rst_valid", 64'(valid), 64'd0);
        check("rst_stuck", 64'(stuck), 64'd0);
        check("rst_stuck_level", 64'(stuck_level), 64'd0);
        tick(3);
        rst = 1'b1;

        // Line held low from reset.
        tick(TIMEOUT - 10);
        check("idle_not_yet_stuck", 64'(stuck), 64'd0);
        tick(20);
        check("idle_stuck", 64'(stuck), 64'd1);
        check("idle_stuck_level", 64'(stuck_level), 64'd0);

        // Nominal 50 % duty stream.
        for (int i = 0; i < 5; i++) period(125, 250);
        check("stuck_cleared", 64'(stuck), 64'd0);

        // Extreme and mid high times.
        period(1, 250);
        period(249, 250);
        period(100, 250);
        period(125, 250);

        // Period exactly at TIMEOUT is reported; one longer is not.
        period(250, TIMEOUT);
        period(250, TIMEOUT + 1);
        period(125, 250);

        // Randomized periods within the measurable range.
        for (int i = 0; i < 25; i++) begin
            int p;
            int h;
            p = int'($urandom_range(2, 400));
            h = int'($urandom_range(1, p - 1));
            period(h, p);
        end

        // Line stuck high after a rise.
        pin(1'b1, TIMEOUT - 20);
        check("high_not_yet_stuck", 64'(stuck), 64'd0);
        pin(1'b1, 120);
        check("high_stuck", 64'(stuck), 64'd1);
        check("high_stuck_level", 64'(stuck_level), 64'd1);
        check("held_duty", 64'(duty_out), 64'(last_duty));
        check("held_period", 64'(period_out), 64'(last_per));
        pin(1'b0, 40);
        period(50, 250);
        check("stuck_cleared_on_rise", 64'(stuck), 64'd0);
        period(50, 250);
        period(50, 250);

        // Reset pulsed in the middle of a high phase.
        period(125, 250);
        pin(1'b1, 50);
        rst = 1'b0;
        armed     = 1'b0;
        last_duty = 0;
        last_per  = 0;
        #1;
        check("midrst_duty", 64'(duty_out), 64'd0);
        check("midrst_period", 64'(period_out), 64'd0);
        check("midrst_valid", 64'(valid), 64'd0);
        check("midrst_stuck", 64'(stuck), 64'd0);
        pin(1'b1, 75);
        pin(1'b0, 50);
        rst = 1'b1;
        pin(1'b0, 75);
        for (int i = 0; i < 3; i++) period(125, 250);

        // Capture disabled mid-period.
        pin(1'b1, 50);
        en    = 1'b0;
        armed = 1'b0;
        pin(1'b1, 30);
        en = 1'b1;
        pin(1'b1, 45);
        pin(1'b0, 125);
        for (int i = 0; i < 3; i++) period(125, 250);

        pin(1'b1, 20);
        tick(10);
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- Receive-side counterpart of the team's PWM generator: samples an external PWM line and measures the high time and period, in clk cycles, of each complete cycle.
- Reports one measurement per PWM period with a single-cycle valid strobe.
- Flags a stuck line (0 % / 100 % duty, or no signal).
- Sits behind a pin input, feeding the demodulation/decoder logic, e.g. recovering the 15-bit duty word of a 25000-cycle PWM frame.

Parameters:
- CNT_W, 16, width of the internal counters and of duty_out/period_out.
- TIMEOUT, 50000, cycles without a completed period before the stuck condition; must be < 2^CNT_W.
- SYNC_STAGES, 2, flip-flops in the input synchronizer (minimum 2).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  capture enable; low forces IDLE, counters cleared, outputs held.
- pwm_in  in  1  asynchronous PWM input line.
- duty_out  out  CNT_W  high time, in clk cycles, of the last complete period.
- period_out  out  CNT_W  rise-to-rise period, in clk cycles, of the last complete period.
- valid  out  1  one-cycle pulse when duty_out/period_out update.
- stuck  out  1  high while the line is considered stuck.
- stuck_level  out  1  pwm level sampled when stuck asserted.

Behaviour:
- Reset (rst low, asynchronous):
  - All synchronizer flops, the edge-detect register, counters, duty_out, period_out, valid, stuck and stuck_level go to 0.
  - FSM goes to IDLE.
- Synchronizer: pwm_in passes through SYNC_STAGES flops to give s. prev holds s delayed by one cycle.
  - rise = s & ~prev
  - fall = ~s & prev
- FSM states: IDLE, HIGH, LOW.
- IDLE:
  - Wait for rise; no measurement is produced from a partial first period.
  - On rise: period_cnt <= 1, high_cnt <= 1, go to HIGH.
- HIGH:
  - Each cycle period_cnt +1 and high_cnt +1.
  - On fall: high_cnt freezes (not incremented that cycle), go to LOW.
- LOW:
  - Each cycle period_cnt +1.
  - On rise: period_out <= period_cnt, duty_out <= high_cnt, valid <= 1 (next cycle, exactly one cycle wide), period_cnt <= 1, high_cnt <= 1, go to HIGH.
- Result: for an input with high time H and period P (cycles), duty_out = H and period_out = P exactly.
- Latency: valid rises SYNC_STAGES+2 clk after the pwm_in rising edge that closes the period.
- Timeout:
  - In HIGH or LOW, when period_cnt reaches TIMEOUT: stuck <= 1, stuck_level <= s, go to IDLE.
  - No valid pulse; duty_out/period_out keep their last values.
  - In IDLE, a free-running idle counter also raises stuck at TIMEOUT, so a line never toggling after reset is flagged.
  - stuck clears on the next rise.
- Counter arithmetic: unsigned. Counters saturate at TIMEOUT and never wrap.
- Glitches:
  - A 1-cycle pulse on s is a legal measurement: H = 1.
  - No debounce.
- Simultaneous events:
  - In LOW, rise in the same cycle period_cnt hits TIMEOUT: rise wins (measurement reported, no stuck).
  - en low has priority over everything except reset.
- en:
  - Deassert mid-period: the partial period is discarded.
  - On re-enable, start in IDLE.
- Reset mid-period: all state cleared. The first measurement after release requires two rising edges.

Test Plan:
- 25000-cycle period, 12500 high, 4 periods, SYNC_STAGES=2 -> no valid after the first rise, then valid pulses with duty_out=12500, period_out=25000, each exactly 1 cycle wide and 4 cycles after the closing pin edge.
- Periods with high times 1, 24999 and 100 (period 25000) -> duty_out 1/24999/100, period_out 25000 each time; stuck stays 0.
- pwm_in held high 60000 cycles after a rise -> stuck=1 and stuck_level=1 at period_cnt=50000, no valid, duty/period unchanged. Then resume a 25000/5000 PWM -> stuck clears on the first rise, valid with 5000/25000 after one full period.
- pwm_in held low from reset -> stuck=1, stuck_level=0 after 50000 cycles.
- rst pulsed low mid-HIGH during a 25000/12500 stream -> all outputs 0 asynchronously, no valid until the second rise after release.
- en dropped for 3000 cycles mid-period -> the partial period is not reported; the next report is a clean 25000/12500.
